// File: rtl/seq_src_pkg.sv
// Shared types and helpers for the serial bit source.
// The LFSR helpers are only used when SRC_LFSR_EN is defined.
package seq_src_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } src_state_t;

    // Right-shifting Fibonacci form of taps 16,14,13,11
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic int clamp_len(input int len, input int pat_w);
        return (len == 0 || len > pat_w) ? pat_w : len;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/seq_bit_source_if.sv
// Control and serial-output bundle of the bit source.
// Carries lfsr_sel only when SRC_LFSR_EN is defined.
interface seq_bit_source_if #(
    parameter int PAT_W = 16
);
    localparam int LW = $clog2(PAT_W) + 1;
    localparam int IW = $clog2(PAT_W);

    logic          en;
    logic          load;
    logic [PAT_W-1:0] load_pattern;
    logic [LW-1:0] load_len;
`ifdef SRC_LFSR_EN
    logic          lfsr_sel;
`endif
    logic          x;
    logic          x_valid;
    logic [IW-1:0] bit_idx;
    logic          frame_done;

`ifdef SRC_LFSR_EN
    modport master (
        output en, load, load_pattern, load_len, lfsr_sel,
        input  x, x_valid, bit_idx, frame_done
    );
    modport slave (
        input  en, load, load_pattern, load_len, lfsr_sel,
        output x, x_valid, bit_idx, frame_done
    );
`else
    modport master (
        output en, load, load_pattern, load_len,
        input  x, x_valid, bit_idx, frame_done
    );
    modport slave (
        input  en, load, load_pattern, load_len,
        output x, x_valid, bit_idx, frame_done
    );
`endif

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to one tick every DIV_COUNT running cycles.
// tick is combinational so the caller can act on it in the same edge.
module tick_prescaler #(
    parameter int DIV_COUNT = 20000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(DIV_COUNT);

    logic [CW-1:0] r_cnt;

    assign tick = run && !clr && (r_cnt == CW'(DIV_COUNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || !run || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_bit_source.sv
// Programmable serial bit source feeding the sequence detector.
// Define SRC_LFSR_EN to add a selectable 16-bit LFSR bit stream.
module seq_bit_source
    import seq_src_pkg::*;
#(
    parameter int               DIV_COUNT = 20000000,
    parameter int               PAT_W     = 16,
    parameter logic [PAT_W-1:0] PATTERN   = 16'h3B6D,
    parameter int               PAT_LEN   = 16
) (
    input logic             clk,
    input logic             rst_n,
    seq_bit_source_if.slave bus
);
    localparam int LW = $clog2(PAT_W) + 1;
    localparam int IW = $clog2(PAT_W);

    src_state_t       r_state;
    logic [PAT_W-1:0] r_pat;
    logic [LW-1:0]    r_len;
    logic [IW-1:0]    r_bit_idx;
    logic             r_x;
    logic             r_x_valid;
    logic             r_frame_done;

    logic w_run;
    logic w_tick;
    logic w_last;
    logic w_bit;

    // en is looked at directly so a falling en blocks a pending tick
    assign w_run  = (r_state == RUN) && bus.en;
    assign w_last = ({1'b0, r_bit_idx} == r_len - 1'b1);

`ifdef SRC_LFSR_EN
    logic [15:0] r_lfsr;
    assign w_bit = bus.lfsr_sel ? r_lfsr[0] : r_pat[r_bit_idx];
`else
    assign w_bit = r_pat[r_bit_idx];
`endif

    tick_prescaler #(
        .DIV_COUNT (DIV_COUNT)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .clr   (bus.load),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pat        <= PATTERN;
            r_len        <= LW'(clamp_len(PAT_LEN, PAT_W));
            r_bit_idx    <= '0;
            r_x          <= 1'b0;
            r_x_valid    <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef SRC_LFSR_EN
            r_lfsr       <= LFSR_SEED;
`endif
        end else begin
            r_x_valid    <= 1'b0;
            r_frame_done <= 1'b0;
            if (bus.load) begin
                r_pat     <= bus.load_pattern;
                r_len     <= LW'(clamp_len(int'(bus.load_len), PAT_W));
                r_bit_idx <= '0;
`ifdef SRC_LFSR_EN
                r_lfsr    <= (bus.load_pattern[15:0] != 16'h0) ?
                             bus.load_pattern[15:0] : LFSR_SEED;
`endif
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (bus.en) r_state <= RUN;
                    end
                    RUN: begin
                        if (!bus.en) begin
                            r_state <= IDLE;
                        end else if (w_tick) begin
                            r_x          <= w_bit;
                            r_x_valid    <= 1'b1;
                            r_frame_done <= w_last;
                            r_bit_idx    <= w_last ? '0 : r_bit_idx + 1'b1;
`ifdef SRC_LFSR_EN
                            if (bus.lfsr_sel) r_lfsr <= lfsr_next(r_lfsr);
`endif
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.x          = r_x;
    assign bus.x_valid    = r_x_valid;
    assign bus.bit_idx    = r_bit_idx;
    assign bus.frame_done = r_frame_done;

endmodule
